encoder_frame_scheduler: RTL and testbench

ENCODER_FRAME_SCHEDULER -- requirements
Module: encoder_frame_scheduler

---
 rtl/encoder_frame_scheduler.sv | 153 +++++++++++++++
 tb/tb_encoder_frame_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_frame_scheduler.sv
// Frame scheduler for a shared convolutional encoder: round-robin grant between two
// requesters, then sequences clear, encode, trellis termination and an inter-frame gap.
module encoder_frame_scheduler #(
  parameter int unsigned TAIL_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [8:0] len0,
  input  logic [8:0] len1,
  output logic [1:0] grant,
  output logic       src_sel,
  output logic       clr,
  output logic       enc_enable,
  output logic       trellis_enable,
  output logic [1:0] frame_done,
  output logic       busy,
  output logic [2:0] state,
  output logic [7:0] frames0,
  output logic [7:0] frames1
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_TERM   = 3'd2,
    S_ENCODE = 3'd3,
    S_GAP    = 3'd4
  } state_e;

  localparam logic [3:0] TAIL_LAST = 4'(TAIL_CYCLES - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic [8:0] cnt_q, cnt_d;
  logic [3:0] phase_q, phase_d;
  logic [7:0] frames0_q, frames0_d;
  logic [7:0] frames1_q, frames1_d;
  logic       winner;
  logic [1:0] owner_onehot;

  // Single requests always win; on contention the one not served last wins.
  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      default: winner = ~last_q;
    endcase
  end

  assign owner_onehot = owner_q ? 2'b10 : 2'b01;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_d         = last_q;
    cnt_d          = cnt_q;
    phase_d        = phase_q;
    frames0_d      = frames0_q;
    frames1_d      = frames1_q;
    grant          = 2'b00;
    clr            = 1'b0;
    enc_enable     = 1'b0;
    trellis_enable = 1'b0;
    frame_done     = 2'b00;
    busy           = 1'b1;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (req != 2'b00) begin
          owner_d = winner;
          last_d  = winner;
          cnt_d   = winner ? len1 : len0;
          phase_d = 4'd0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        grant   = owner_onehot;
        clr     = 1'b1;
        state_d = S_ENCODE;
      end
      S_ENCODE: begin
        grant      = owner_onehot;
        enc_enable = 1'b1;
        if (cnt_q == 9'd0) begin
          phase_d = 4'd0;
          state_d = S_TERM;
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      S_TERM: begin
        grant          = owner_onehot;
        trellis_enable = 1'b1;
        if (phase_q == TAIL_LAST) begin
          phase_d = 4'd0;
          state_d = S_GAP;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      S_GAP: begin
        // Completion is reported once, on the first gap cycle.
        if (phase_q == 4'd0) begin
          frame_done = owner_onehot;
          if (owner_q) frames1_d = frames1_q + 8'd1;
          else         frames0_d = frames0_q + 8'd1;
        end
        if (phase_q == GAP_LAST) begin
          phase_d = 4'd0;
          state_d = S_IDLE;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= 9'd0;
      phase_q   <= 4'd0;
      frames0_q <= 8'd0;
      frames1_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      frames0_q <= frames0_d;
      frames1_q <= frames1_d;
    end
  end

  assign state   = state_q;
  assign src_sel = owner_q;
  assign frames0 = frames0_q;
  assign frames1 = frames1_q;

endmodule

// File: tb/tb_encoder_frame_scheduler.sv
// Self-checking bench: a frame-timeline reference model checked every cycle, plus
// directed scenario tasks with their own fixed expectations.
module tb_encoder_frame_scheduler;

  localparam int TAIL = 4;
  localparam int GAP  = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic [8:0] len0 = 9'd0;
  logic [8:0] len1 = 9'd0;
  logic [1:0] grant;
  logic       src_sel;
  logic       clr;
  logic       enc_enable;
  logic       trellis_enable;
  logic [1:0] frame_done;
  logic       busy;
  logic [2:0] state;
  logic [7:0] frames0;
  logic [7:0] frames1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: a frame is a timeline indexed by m_k cycles since its CLEAR cycle.
  bit m_active = 0;
  bit m_owner  = 0;
  bit m_last   = 1;
  bit m_src    = 0;
  int m_len    = 0;
  int m_k      = 0;
  int m_frames [2] = '{0, 0};

  encoder_frame_scheduler #(.TAIL_CYCLES(TAIL), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .req(req), .len0(len0), .len1(len1),
    .grant(grant), .src_sel(src_sel), .clr(clr), .enc_enable(enc_enable),
    .trellis_enable(trellis_enable), .frame_done(frame_done), .busy(busy),
    .state(state), .frames0(frames0), .frames1(frames1)
  );

  always #5 clk = ~clk;

  // One clock: advance the model at the edge, then compare all outputs mid-cycle.
  task automatic cycle();
    int         done_k;
    bit         w;
    logic [2:0] e_state;
    logic [1:0] e_grant;
    logic [1:0] e_fd;
    int         n_en;
    @(posedge clk);
    if (reset) begin
      m_active = 0; m_k = 0; m_last = 1; m_src = 0; m_frames[0] = 0; m_frames[1] = 0;
    end else if (!m_active) begin
      if (req != 2'b00) begin
        w = (req == 2'b11) ? !m_last : req[1];
        m_owner = w; m_last = w; m_src = w;
        m_len = w ? int'(len1) : int'(len0);
        m_active = 1; m_k = 0;
      end
    end else begin
      if (m_k == m_len + 2 + TAIL) m_frames[m_owner] = (m_frames[m_owner] + 1) % 256;
      m_k++;
      if (m_k == m_len + 2 + TAIL + GAP) m_active = 0;
    end
    @(negedge clk);
    cyc++;
    done_k  = m_len + 2 + TAIL;
    e_state = !m_active ? 3'd0 : (m_k == 0) ? 3'd1 : (m_k <= m_len + 1) ? 3'd3 :
              (m_k < done_k) ? 3'd2 : 3'd4;
    e_grant = (m_active && m_k < done_k) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    e_fd    = (m_active && m_k == done_k) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    total++;
    if (state !== e_state) begin
      bad++; $display("FAIL state cyc=%0d got=%0d exp=%0d", cyc, state, e_state);
    end
    total++;
    if (grant !== e_grant) begin
      bad++; $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, grant, e_grant);
    end
    total++;
    if (frame_done !== e_fd) begin
      bad++; $display("FAIL frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, e_fd);
    end
    total++;
    if ({clr, enc_enable, trellis_enable, busy} !==
        {e_state == 3'd1, e_state == 3'd3, e_state == 3'd2, m_active}) begin
      bad++;
      $display("FAIL enables cyc=%0d got clr/enc/trl/busy=%b%b%b%b exp=%b%b%b%b", cyc,
               clr, enc_enable, trellis_enable, busy,
               e_state == 3'd1, e_state == 3'd3, e_state == 3'd2, m_active);
    end
    total++;
    if (src_sel !== m_src) begin
      bad++; $display("FAIL src_sel cyc=%0d got=%b exp=%b", cyc, src_sel, m_src);
    end
    total++;
    if (frames0 !== 8'(m_frames[0]) || frames1 !== 8'(m_frames[1])) begin
      bad++;
      $display("FAIL frames cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, frames0, frames1,
               m_frames[0], m_frames[1]);
    end
    n_en = int'(clr) + int'(enc_enable) + int'(trellis_enable);
    total++;
    if (!$onehot0(grant) || n_en > 1) begin
      bad++; $display("FAIL exclusive cyc=%0d got grant=%b enables=%0d exp onehot0/<=1",
                      cyc, grant, n_en);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 2'b11; len0 = 9'd7; len1 = 9'd7;
    repeat (3) cycle();
    total++;
    if ({state, grant, src_sel, clr, enc_enable, trellis_enable, frame_done, busy} !== 12'd0
        || frames0 !== 8'd0 || frames1 !== 8'd0) begin
      bad++; $display("FAIL reset_values got state=%0d grant=%b busy=%b frames=%0d/%0d exp all 0",
                      state, grant, busy, frames0, frames1);
    end
    req = 2'b00;
    reset = 1'b0;
    cycle();
  endtask

  // Cycle c is the c-th cycle after the edge that first samples req.
  task automatic test_single_frame();
    req = 2'b01; len0 = 9'd3;
    for (int c = 1; c <= 11; c++) begin
      cycle();
      if (c == 1) req = 2'b00;
      total++;
      if (clr !== (c == 1) || enc_enable !== (c >= 2 && c <= 5) ||
          trellis_enable !== (c >= 6 && c <= 9)) begin
        bad++; $display("FAIL single_enables c=%0d got clr/enc/trl=%b%b%b", c, clr,
                        enc_enable, trellis_enable);
      end
      total++;
      if (frame_done !== ((c == 10) ? 2'b01 : 2'b00)) begin
        bad++; $display("FAIL single_done c=%0d got=%b", c, frame_done);
      end
    end
    total++;
    if (state !== 3'd0 || frames0 !== 8'd1) begin
      bad++; $display("FAIL single_end got state=%0d frames0=%0d exp 0/1", state, frames0);
    end
  endtask

  task automatic test_alternate();
    logic [1:0] grants [$];
    int         at [$];
    do_reset();
    req = 2'b11; len0 = 9'd0; len1 = 9'd0;
    for (int i = 0; i < 32; i++) begin
      cycle();
      if (clr) begin grants.push_back(grant); at.push_back(cyc); end
    end
    req = 2'b00;
    total++;
    if (grants.size() != 4) begin
      bad++; $display("FAIL alt_count got=%0d exp=4", grants.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (grants[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
          bad++; $display("FAIL alt_grant i=%0d got=%b", i, grants[i]);
        end
        if (i > 0) begin
          total++;
          if (at[i] - at[i-1] != 8) begin
            bad++; $display("FAIL alt_period i=%0d got=%0d exp=8", i, at[i] - at[i-1]);
          end
        end
      end
    end
    repeat (10) cycle();
  endtask

  task automatic test_long_frame();
    int run = 0, longest = 0, n = 0;
    bit done = 0;
    req = 2'b10; len1 = 9'd511;
    while (!done && n < 600) begin
      cycle(); n++;
      req = 2'b00;
      run = enc_enable ? run + 1 : 0;
      if (run > longest) longest = run;
      if (frame_done != 2'b00) done = 1;
    end
    total++;
    if (!done || longest != 512) begin
      bad++; $display("FAIL long_encode got=%0d done=%0d exp=512", longest, done);
    end
    repeat (3) cycle();
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    do_reset();
    req = 2'b01; len0 = 9'd20;
    while (!enc_enable && n < 5) begin cycle(); n++; end
    repeat (3) cycle();
    total++;
    if (!enc_enable) begin
      bad++; $display("FAIL midreset_setup got enc=%b exp=1", enc_enable);
    end
    reset = 1'b1;
    cycle();
    total++;
    if ({state, grant, src_sel, clr, enc_enable, trellis_enable, frame_done, busy} !== 12'd0
        || frames0 !== 8'd0) begin
      bad++; $display("FAIL midreset_values got state=%0d grant=%b fd=%b frames0=%0d", state,
                      grant, frame_done, frames0);
    end
    reset = 1'b0; req = 2'b11;
    cycle();
    total++;
    if (grant !== 2'b01) begin
      bad++; $display("FAIL midreset_first got=%b exp=01", grant);
    end
    req = 2'b00;
    repeat (30) cycle();
  endtask

  task automatic test_len_change();
    int n_enc = 0, n_done = 0;
    req = 2'b01; len0 = 9'd5;
    cycle();
    cycle();
    if (enc_enable) n_enc++;
    len0 = 9'd200; req = 2'b00;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (enc_enable) n_enc++;
      if (frame_done[0]) n_done++;
    end
    total++;
    if (n_enc != 6 || n_done != 1) begin
      bad++; $display("FAIL len_change got enc=%0d done=%0d exp 6/1", n_enc, n_done);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      req   = 2'($urandom_range(0, 3));
      len0  = ($urandom_range(0, 9) == 0) ? 9'($urandom) : 9'($urandom_range(0, 12));
      len1  = ($urandom_range(0, 9) == 0) ? 9'($urandom) : 9'($urandom_range(0, 12));
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0; req = 2'b00;
    repeat (600) cycle();
  endtask

  task automatic test_wrap();
    int         pulses = 0, n = 0;
    logic [7:0] at_last = 8'hxx;
    do_reset();
    req = 2'b01; len0 = 9'd0;
    while (pulses < 256 && n < 256 * 8 + 50) begin
      cycle(); n++;
      if (frame_done[0]) begin pulses++; at_last = frames0; end
    end
    req = 2'b00;
    cycle();
    total++;
    if (pulses != 256 || at_last !== 8'd255 || frames0 !== 8'd0) begin
      bad++; $display("FAIL wrap got pulses=%0d before=%0d after=%0d exp 256/255/0", pulses,
                      at_last, frames0);
    end
    repeat (10) cycle();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_alternate();
    test_long_frame();
    test_reset_mid_frame();
    test_len_change();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
